// File: rtl/prio_arbiter_pkg.sv
// Shared types for the priority arbiter: FSM state encoding and policy select values.
package prio_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational circular search: first set bit of vec_i at or above start_i, wrapping N-1 -> 0.
module prio_pick #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  int unsigned p;
  logic [W-1:0] pw;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    p       = 0;
    pw      = '0;
    for (int unsigned k = N; k > 0; k--) begin
      p = 32'(start_i) + k - 1;
      if (p >= N) p = p - N;
      pw = W'(p);
      if (vec_i[pw]) begin
        idx_o   = pw;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Two-state grant arbiter with fixed or round-robin priority and back-to-back re-arbitration on Ack.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] In,
  input  logic         Mode,
  input  logic         Ack,
  output logic [W-1:0] Y,
  output logic         Done
);

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] ptr_inc;
  logic [W-1:0] pick_start;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         accept;

  assign accept  = (state_q == GRANT) && Ack && !EN;
  assign ptr_inc = (y_q == W'(N - 1)) ? '0 : y_q + 1'b1;
  assign ptr_d   = accept ? ptr_inc : ptr_q;

  // Re-arbitration after an accepted grant searches from the already-advanced pointer.
  assign pick_start = (Mode == MODE_RR) ? ptr_d : '0;

  prio_pick #(.N(N)) u_pick (
    .vec_i   (In),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (!EN && pick_found) begin
          state_d = GRANT;
          y_d     = pick_idx;
        end else begin
          y_d = '0;
        end
      end
      GRANT: begin
        if (EN) begin
          state_d = IDLE;
          y_d     = '0;
        end else if (Ack) begin
          if (pick_found) begin
            y_d = pick_idx;
          end else begin
            state_d = IDLE;
            y_d     = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y    = y_q;
  assign Done = (state_q == GRANT);

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter N SHALL be the number of request lines: default 8, legal range 2..32.
REQ-002 Parameter W SHALL be the index width: default $clog2(N), derived, not overridden by users.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 EN  input  1  SHALL be the active-low enable: 0 = arbitrate, 1 = disabled.
REQ-006 In  input  N  SHALL be the request vector: bit i = request from source i.
REQ-007 Mode  input  1  SHALL select the priority policy: 0 = fixed (lowest index wins), 1 = round-robin.
REQ-008 Ack  input  1  SHALL be the consumer acceptance of the current grant.
REQ-009 Y  output  W  SHALL be the registered index of the granted source.
REQ-010 Done  output  1  SHALL be the registered flag that Y holds a valid grant.

Function
REQ-011 FSM states SHALL be IDLE and GRANT; Done = 1 exactly when state = GRANT.
REQ-012 In IDLE with EN=0 and In!=0, the block SHALL enter GRANT at the next edge, loading Y with the selected index (latency 1 cycle).
REQ-013 In IDLE with EN=1 or In=0, the block SHALL stay in IDLE with Y=0 and Done=0.
REQ-014 Fixed mode SHALL select the lowest set index of In.
REQ-015 Round-robin mode SHALL select the first set bit of In found by searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-016 ptr SHALL be W bits, reset to 0, and update to (Y+1) mod N only on an accepted grant (GRANT and Ack=1); ptr SHALL be kept in fixed mode as well.
REQ-017 In GRANT, Y and Done SHALL hold stable until Ack=1 or EN=1, regardless of changes on In or Mode.
REQ-018 On GRANT with Ack=1 and EN=0, the block SHALL re-arbitrate in the same cycle using current In and updated ptr.
REQ-019 If that re-arbitration finds In!=0, the block SHALL stay in GRANT with the new Y, giving back-to-back grants with no idle cycle.
REQ-020 If that re-arbitration finds In=0, the block SHALL go to IDLE with Y=0 and Done=0.
REQ-021 Mode SHALL be sampled only in the cycle an arbitration decision is made.
REQ-022 On EN=1 in GRANT, the block SHALL abort to IDLE at the next edge with Y=0 and Done=0, leaving ptr unchanged, even if Ack=1 in the same cycle.
REQ-023 Ack while in IDLE SHALL be ignored.
REQ-024 Y SHALL be 0 whenever Done=0.

Reset
REQ-025 While rst=1 the block SHALL force state=IDLE, Y=0, Done=0 and ptr=0 immediately, without waiting for clk.
REQ-026 On rst deassertion, the first arbitration SHALL occur at the first edge with EN=0 and In!=0.
REQ-027 A grant in flight at reset SHALL be discarded with no ptr update.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, GRANT) and the mode constants MODE_FIXED=0 and MODE_RR=1.
REQ-029 The combinational search SHALL be one sub-module, prio_pick, with parameter N.
REQ-030 prio_pick SHALL have inputs vector and start index, and outputs index and found.
REQ-031 Fixed mode SHALL reuse prio_pick with start=0.

Verification (N=8)
REQ-032 Fixed-mode scenario: EN=0, Mode=0, In=8'b0010_1000 -> Y=3, Done=1 one cycle later; both held over 5 cycles without Ack.
REQ-033 Round-robin scenario: Mode=1, In=8'hFF, Ack=1 every cycle -> Y sequence 0,1,2,...,7,0 on consecutive cycles with Done=1 continuously.
REQ-034 Round-robin skip scenario: Mode=1, ptr=6, In=8'b0000_0101 -> Y=0; after Ack, ptr=1 and the next grant is Y=2.
REQ-035 Abort scenario: in GRANT (Y=5), EN=1 together with Ack=1 -> next edge Y=0, Done=0, ptr unchanged (next RR grant with In=8'hFF is Y=old ptr).
REQ-036 Stale-request scenario: In falls to 0 during GRANT with Y=4 -> Y=4 and Done=1 held; on Ack -> IDLE with Y=0 and Done=0.
REQ-037 Reset scenario: rst pulsed between edges mid-grant -> Y=0, Done=0 before the next edge; after release, In=8'hFF in RR mode -> Y=0.
